scc_access_scheduler: RTL and testbench
=======================================

# scc_access_scheduler

CPU-side access controller for the SCC wave-table mixer. Accepts SCC/SCC-I bus accesses and decodes them into either direct register updates (frequency, volume, enable) or wave-SRAM accesses. SRAM accesses are rate-limited to one per mixer slot round so CPU traffic cannot starve tone generation. The block sits between the cartridge bus decoder and the channel mixer, and drives the mixer's `sram_*` and `reg_*` inputs.

## Interface
- `FIFO_DEPTH`, 2: request queue depth; power of two, at least 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `req` input 1: access request; accepted when `req && ready`.
- `req_wr` input 1: 1 = write, 0 = read.
- `req_a` input 8: SCC register offset (bus address bits 7:0).
- `req_d` input 8: write data.
- `ready` output 1: queue not full.
- `rdata` output 8: read data.
- `rdata_valid` output 1: one-cycle pulse per completed read.
- `scci_mode` input 1: SCC-I address map select, sampled at decode.
- `active` input 3: mixer slot counter (0..5).
- `sram_id` output 3, `sram_a` output 5, `sram_d` output 8, `sram_oe` output 1, `sram_we` output 1: mixer SRAM port.
- `sram_q` input 8, `sram_q_en` input 1: mixer SRAM read return.
- `reg_frequency_count` output 60: five 12-bit fields; channel n occupies [12n+11:12n].
- `reg_volume` output 20: five 4-bit fields.
- `reg_enable` output 5: channel enables.
- `reg_scci_enable` output 1: registered copy of `scci_mode`.

## Operation
- Every accepted request is pushed to the FIFO as {wr, a, d, mode}. Requests complete strictly in order.
- Decode when `scci_mode` = 0:
  - 0x00–0x7F: wave RAM, id = a[7:5], addr = a[4:0].
  - 0x80–0x89: frequency. Channel (a−0x80)>>1. An even offset writes bits [7:0]; an odd offset writes bits [11:8] from d[3:0].
  - 0x8A–0x8E: volume ch0–4, from d[3:0].
  - 0x8F: enable, from d[4:0].
- Decode when `scci_mode` = 1:
  - 0x00–0x9F: wave RAM for A–E.
  - 0xA0–0xAF: the same register layout as above, shifted by 0x20.
- All other offsets are unmapped: writes are ignored, reads return 0xFF.
- Register reads return 0xFF, because the registers are write-only.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE with a register or unmapped entry at the head: execute it and pop in one cycle. A read sets `rdata_valid` in the next cycle.
  - IDLE with a wave entry at the head and `token` = 1: pop and go to ISSUE. `token` clears.
  - ISSUE: drive `sram_oe` or `sram_we` high for exactly this cycle, with id/a/d valid. Go to WAIT.
  - WAIT: for a read, capture `sram_q` when `sram_q_en` = 1. Return to IDLE.
- `token` sets on any cycle where `active` == 0 and no ISSUE is occurring. Effect: at most one SRAM access per slot round.
- `ready` = registered count < `FIFO_DEPTH`. There is no same-cycle push/pop bypass when full.

## Timing
- Reset values:
  - `ready` = 1, `rdata` = 0x00, `rdata_valid` = 0.
  - All `sram_*` outputs = 0.
  - All `reg_*` outputs = 0; `reg_scci_enable` = 0.
  - FIFO empty, state IDLE, `token` = 1.
- Register write: the `reg_*` output updates 1 cycle after the FIFO pop. A burst of register writes completes at one per cycle.
- Wave read: pop at cycle N, strobe at N+1, `sram_q_en` at N+2, `rdata`/`rdata_valid` at N+3.
- Wave write: `sram_we` is high at N+1 only.
- Reset asserted mid-operation: the FIFO flushes, strobes drop on the next edge, and any pending read produces no `rdata_valid`.
- A push and a pop in the same cycle leave the count unchanged.
- `sram_oe` and `sram_we` are never high together. Neither is ever high in two consecutive cycles.

## Structure
- Shared package `scc_pkg`:
  - address-map constants (wave/register bases for SCC and SCC-I)
  - channel count (5)
  - field widths (12/4/8)
  - FSM state encoding
- Sub-module `scc_access_fifo`: synchronous FIFO with count, `full`/`empty` flags, and a synchronous active-high flush.

## Test plan
- Reset, then check every output against its reset value.
- SCC mode: write 0x80←0x34, then 0x81←0x12 → `reg_frequency_count`[11:0] = 0x234. Write 0x8F←0x1F → `reg_enable` = 5'h1F.
- SCC mode: write 0x45←0xA5 → a single `sram_we` pulse with `sram_id` = 2, `sram_a` = 5, `sram_d` = 0xA5, issued only after `active` has passed 0.
- SCC-I mode: read 0x85 with the mixer returning 0x5C → `sram_oe` with id = 4, a = 5, then `rdata` = 0x5C with `rdata_valid` 3 cycles after the pop. A read of 0x8A → 0xFF.
- Push 4 wave writes back-to-back → `ready` drops after 2 are queued, and exactly one `sram_we` occurs per `active` 0→5 round.
- Assert `reset` during WAIT of a pending read → no `rdata_valid`, FIFO empty, `ready` = 1 on the following cycle.

Source files
------------

// File: rtl/scc_pkg.sv
// scc_pkg: shared address map, field widths, FSM encoding and decode helper
// for the SCC access scheduler.
package scc_pkg;

    localparam int NUM_CH = 5;
    localparam int FREQ_W = 12;
    localparam int VOL_W  = 4;
    localparam int DATA_W = 8;

    localparam logic [7:0] SCC_WAVE_END  = 8'h7F;
    localparam logic [7:0] SCC_REG_BASE  = 8'h80;
    localparam logic [7:0] SCCI_WAVE_END = 8'h9F;
    localparam logic [7:0] SCCI_REG_BASE = 8'hA0;
    localparam logic [7:0] REG_SPAN      = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        K_WAVE,
        K_FREQ_LO,
        K_FREQ_HI,
        K_VOL,
        K_EN,
        K_NONE
    } kind_t;

    typedef struct packed {
        logic              wr;
        logic [7:0]        a;
        logic [DATA_W-1:0] d;
        logic              mode;
    } entry_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] ch;
    } decode_t;

    // For wave entries ch carries the SRAM id (a[7:5]).
    function automatic decode_t decode(input logic [7:0] a, input logic mode);
        decode_t    r;
        logic [7:0] base;
        logic [7:0] off;
        r.kind = K_NONE;
        r.ch   = a[7:5];
        base   = mode ? SCCI_REG_BASE : SCC_REG_BASE;
        off    = a - base;
        if (a <= (mode ? SCCI_WAVE_END : SCC_WAVE_END)) begin
            r.kind = K_WAVE;
        end else if (a >= base && off < REG_SPAN) begin
            if (off < 8'h0A) begin
                r.kind = off[0] ? K_FREQ_HI : K_FREQ_LO;
                r.ch   = off[3:1];
            end else if (off < 8'h0F) begin
                r.kind = K_VOL;
                r.ch   = 3'(off - 8'h0A);
            end else begin
                r.kind = K_EN;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scc_access_fifo.sv
// scc_access_fifo: small synchronous FIFO with occupancy count and a
// synchronous flush that doubles as its reset.
module scc_access_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scc_access_scheduler.sv
// scc_access_scheduler: CPU bus front end for the SCC wave-table mixer.
// Queues accesses in order and throttles wave-SRAM traffic to one per slot round.
module scc_access_scheduler
    import scc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_wr,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_d,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    input  logic        scci_mode,
    input  logic [2:0]  active,
    output logic [2:0]  sram_id,
    output logic [4:0]  sram_a,
    output logic [7:0]  sram_d,
    output logic        sram_oe,
    output logic        sram_we,
    input  logic [7:0]  sram_q,
    input  logic        sram_q_en,
    output logic [59:0] reg_frequency_count,
    output logic [19:0] reg_volume,
    output logic [4:0]  reg_enable,
    output logic        reg_scci_enable
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_n;
    entry_t            head;
    decode_t           hd;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              launch;
    logic              exec;
    logic              token;
    logic              cur_wr;
    logic [FREQ_W-1:0] freq [NUM_CH];
    logic [VOL_W-1:0]  vol  [NUM_CH];

    assign ready = count < CW'(FIFO_DEPTH);
    assign push  = req && !full;
    assign hd    = decode(head.a, head.mode);

    scc_access_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .flush (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({req_wr, req_a, req_d, scci_mode}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pack
        assign reg_frequency_count[i*FREQ_W +: FREQ_W] = freq[i];
        assign reg_volume[i*VOL_W +: VOL_W]            = vol[i];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        launch  = 1'b0;
        exec    = 1'b0;
        sram_oe = 1'b0;
        sram_we = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    if (hd.kind != K_WAVE) begin
                        pop  = 1'b1;
                        exec = 1'b1;
                    end else if (token) begin
                        pop     = 1'b1;
                        launch  = 1'b1;
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                sram_oe = !cur_wr;
                sram_we = cur_wr;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (cur_wr || sram_q_en) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            token           <= 1'b1;
            cur_wr          <= 1'b0;
            sram_id         <= '0;
            sram_a          <= '0;
            sram_d          <= '0;
            rdata           <= '0;
            rdata_valid     <= 1'b0;
            reg_enable      <= '0;
            reg_scci_enable <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                freq[i] <= '0;
                vol[i]  <= '0;
            end
        end else begin
            rdata_valid     <= 1'b0;
            reg_scci_enable <= scci_mode;
            // Claiming the token wins over re-arming it in the same cycle.
            if (launch) token <= 1'b0;
            else if (active == 3'd0 && state != ST_ISSUE) token <= 1'b1;
            if (launch) begin
                cur_wr  <= head.wr;
                sram_id <= hd.ch;
                sram_a  <= head.a[4:0];
                sram_d  <= head.d;
            end
            if (exec && !head.wr) begin
                rdata       <= 8'hFF;
                rdata_valid <= 1'b1;
            end
            if (exec && head.wr) begin
                case (hd.kind)
                    K_FREQ_LO: freq[hd.ch][7:0]  <= head.d;
                    K_FREQ_HI: freq[hd.ch][11:8] <= head.d[3:0];
                    K_VOL:     vol[hd.ch]        <= head.d[3:0];
                    K_EN:      reg_enable        <= head.d[4:0];
                    default:   ;
                endcase
            end
            if (state == ST_WAIT && !cur_wr && sram_q_en) begin
                rdata       <= sram_q;
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scc_access_scheduler.sv
// tb_scc_access_scheduler: directed and random accesses against a
// behavioural model of the SCC register map and mixer wave RAM.
module tb_scc_access_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_wr;
    logic [7:0]  req_a;
    logic [7:0]  req_d;
    logic        ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        scci_mode;
    logic [2:0]  active;
    logic [2:0]  sram_id;
    logic [4:0]  sram_a;
    logic [7:0]  sram_d;
    logic        sram_oe;
    logic        sram_we;
    logic [7:0]  sram_q;
    logic        sram_q_en;
    logic [59:0] reg_frequency_count;
    logic [19:0] reg_volume;
    logic [4:0]  reg_enable;
    logic        reg_scci_enable;

    always #5 clk = ~clk;

    scc_access_scheduler #(.FIFO_DEPTH(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .req_wr              (req_wr),
        .req_a               (req_a),
        .req_d               (req_d),
        .ready               (ready),
        .rdata               (rdata),
        .rdata_valid         (rdata_valid),
        .scci_mode           (scci_mode),
        .active              (active),
        .sram_id             (sram_id),
        .sram_a              (sram_a),
        .sram_d              (sram_d),
        .sram_oe             (sram_oe),
        .sram_we             (sram_we),
        .sram_q              (sram_q),
        .sram_q_en           (sram_q_en),
        .reg_frequency_count (reg_frequency_count),
        .reg_volume          (reg_volume),
        .reg_enable          (reg_enable),
        .reg_scci_enable     (reg_scci_enable)
    );

    typedef struct {
        logic       wr;
        logic [2:0] id;
        logic [4:0] addr;
        logic [7:0] d;
    } strobe_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_model [5][32];
    logic [7:0]  sram_mem  [5][32];
    logic [11:0] m_freq [5];
    logic [3:0]  m_vol  [5];
    logic [4:0]  m_en;
    strobe_t     exp_strobe [$];
    logic [7:0]  exp_rd [$];

    int   cyc = 0;
    int   oe_cyc = 0;
    int   rdv_cyc = 0;
    int   round_cnt = 0;
    int   n_strobe = 0;
    logic prev_s = 1'b0;
    logic oe_prev = 1'b0;
    logic [7:0] q_prev = 8'h00;
    logic hold = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply one access to the register/RAM model in program order.
    task automatic model(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic mode);
        int ai;
        int r;
        int id;
        int ad;
        strobe_t s;
        ai = int'(a);
        r = -1;
        if (!mode && ai >= 128 && ai < 144) r = ai - 128;
        if (mode && ai >= 160 && ai < 176) r = ai - 160;
        if (mode ? (ai < 160) : (ai < 128)) begin
            id = ai / 32;
            ad = ai % 32;
            s.wr = wr;
            s.id = 3'(id);
            s.addr = 5'(ad);
            s.d = d;
            exp_strobe.push_back(s);
            if (wr) mem_model[id][ad] = d;
            else exp_rd.push_back(mem_model[id][ad]);
        end else if (!wr) begin
            exp_rd.push_back(8'hFF);
        end else if (r >= 0 && r < 10) begin
            if (r % 2 == 0) m_freq[r/2][7:0] = d;
            else m_freq[r/2][11:8] = d[3:0];
        end else if (r >= 10 && r < 15) begin
            m_vol[r-10] = d[3:0];
        end else if (r == 15) begin
            m_en = d[4:0];
        end
    endtask

    task automatic clear_model();
        exp_strobe.delete();
        exp_rd.delete();
        for (int i = 0; i < 5; i++) begin
            m_freq[i] = 12'h000;
            m_vol[i] = 4'h0;
        end
        m_en = 5'h00;
    endtask

    task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic mode);
        int n;
        n = 0;
        req = 1'b1;
        req_wr = wr;
        req_a = a;
        req_d = d;
        scci_mode = mode;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", n < 300, 1);
        model(wr, a, d, mode);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_strobe.size() != 0 || exp_rd.size() != 0 || !ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", n < 1000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        logic [59:0] f;
        logic [19:0] v;
        for (int i = 0; i < 5; i++) begin
            f[i*12 +: 12] = m_freq[i];
            v[i*4 +: 4] = m_vol[i];
        end
        check({tag, "_freq"}, reg_frequency_count, f);
        check({tag, "_vol"}, reg_volume, v);
        check({tag, "_en"}, reg_enable, m_en);
    endtask

    // Monitor, mixer SRAM responder and slot counter, all on the falling edge.
    always @(negedge clk) begin
        logic s;
        strobe_t es;
        cyc++;
        s = sram_oe | sram_we;
        if (active == 3'd0) round_cnt = 0;
        if (s) begin
            round_cnt++;
            n_strobe++;
            oe_cyc = cyc;
            check("strobe_exclusive", sram_oe & sram_we, 0);
            check("strobe_repeat", prev_s, 0);
            check("one_per_round", round_cnt <= 1, 1);
            check("strobe_pending", exp_strobe.size() > 0, 1);
            if (exp_strobe.size() > 0) begin
                es = exp_strobe.pop_front();
                check("strobe_fields",
                      {sram_we, sram_id, sram_a, sram_we ? sram_d : 8'h00},
                      {es.wr, es.id, es.addr, es.wr ? es.d : 8'h00});
            end
        end
        if (rdata_valid) begin
            rdv_cyc = cyc;
            check("rdata_pending", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) check("rdata", rdata, exp_rd.pop_front());
        end
        sram_q_en = oe_prev;
        sram_q = q_prev;
        oe_prev = sram_oe;
        if (sram_oe && sram_id < 3'd5) q_prev = sram_mem[sram_id][sram_a];
        if (sram_we && sram_id < 3'd5) sram_mem[sram_id][sram_a] = sram_d;
        prev_s = s;
        if (!(hold && active == 3'd3)) active = (active == 3'd5) ? 3'd0 : active + 3'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic v;
        reset = 1'b1;
        req = 1'b0;
        req_wr = 1'b0;
        req_a = 8'h00;
        req_d = 8'h00;
        scci_mode = 1'b0;
        active = 3'd0;
        sram_q = 8'h00;
        sram_q_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 32; j++) begin
                mem_model[i][j] = 8'($urandom);
                sram_mem[i][j] = mem_model[i][j];
            end
        end
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_ready", ready, 1);
        check("rst_rdata", {rdata, rdata_valid}, 0);
        check("rst_sram", {sram_id, sram_a, sram_d, sram_oe, sram_we}, 0);
        check("rst_freq", reg_frequency_count, 0);
        check("rst_vol_en", {reg_volume, reg_enable, reg_scci_enable}, 0);

        push(1'b1, 8'h80, 8'h34, 1'b0);
        push(1'b1, 8'h81, 8'h12, 1'b0);
        drain();
        check("freq0", reg_frequency_count[11:0], 12'h234);
        push(1'b1, 8'h8F, 8'h1F, 1'b0);
        drain();
        check("enable", reg_enable, 5'h1F);

        for (int i = 0; i < 5; i++) push(1'b1, 8'(8'h8A + i), 8'(8'h3 + i), 1'b0);
        @(negedge clk);
        check("vol_burst", reg_volume, {4'h7, 4'h6, 4'h5, 4'h4, 4'h3});
        check_regs("scc_regs");

        push(1'b1, 8'h45, 8'hA5, 1'b0);
        push(1'b1, 8'h46, 8'h5A, 1'b0);
        drain();
        check("wave_write_mem", {sram_mem[2][5], sram_mem[2][6]}, 16'hA55A);

        mem_model[4][5] = 8'h5C;
        sram_mem[4][5] = 8'h5C;
        push(1'b0, 8'h85, 8'h00, 1'b1);
        drain();
        check("read_latency", rdv_cyc - oe_cyc, 2);
        check("read_value", rdata, 8'h5C);
        check("scci_enable", reg_scci_enable, 1);
        push(1'b0, 8'h8A, 8'h00, 1'b0);
        drain();
        check("reg_read_ff", rdata, 8'hFF);
        push(1'b0, 8'hAA, 8'h00, 1'b1);
        push(1'b0, 8'hC3, 8'h00, 1'b1);
        drain();
        check("unmapped_read_ff", rdata, 8'hFF);

        hold = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = n_strobe;
        push(1'b1, 8'h11, 8'h01, 1'b0);
        repeat (6) @(negedge clk);
        check("bp_first_issued", exp_strobe.size(), 0);
        push(1'b1, 8'h12, 8'h02, 1'b0);
        push(1'b1, 8'h33, 8'h03, 1'b0);
        check("bp_ready_low", ready, 0);
        hold = 1'b0;
        push(1'b1, 8'h54, 8'h04, 1'b0);
        push(1'b1, 8'h75, 8'h05, 1'b0);
        drain();
        check("bp_strobes", n_strobe - base, 5);

        base = n_strobe;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            logic md;
            logic [7:0] a;
            md = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 255));
                1: a = md ? 8'($urandom_range(160, 175)) : 8'($urandom_range(128, 143));
                2: a = 8'($urandom_range(0, md ? 159 : 127));
                default: a = 8'($urandom_range(128, 255));
            endcase
            if (md ? (a < 8'd160) : (a < 8'd128)) n++;
            push(1'($urandom_range(0, 1)), a, 8'($urandom), md);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        drain();
        check_regs("rand_regs");
        check("rand_strobes", n_strobe - base, n);

        push(1'b0, 8'h25, 8'h00, 1'b0);
        push(1'b1, 8'h8F, 8'h1F, 1'b0);
        n = 0;
        while (!sram_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_oe_seen", n < 50, 1);
        @(negedge clk);
        reset = 1'b1;
        exp_rd.delete();
        exp_strobe.delete();
        @(negedge clk);
        check("mid_no_valid", rdata_valid, 0);
        check("mid_strobes", {sram_oe, sram_we}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_ready", ready, 1);
        v = rdata_valid;
        check("mid_no_valid2", v, 0);
        repeat (4) @(negedge clk);
        check("mid_flushed", reg_enable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
